// File: rtl/skid_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel, with a registered output stage and a one-entry skid slot.
// Define SKID_RR_ARBITER_LOCK_EN for packet mode (no interleaving of packets between ports).
module skid_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_bus,
  input  logic [NUM_PORTS-1:0]            up_last,
  input  logic [NUM_PORTS-1:0]            up_val,
  output logic [NUM_PORTS-1:0]            up_rdy,
  output logic [DATA_WIDTH-1:0]           dn_bus,
  output logic                            dn_last,
  output logic [ID_WIDTH-1:0]             dn_id,
  output logic                            dn_val,
  input  logic                            dn_rdy
);

  localparam int SUM_WIDTH = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0]   r_sel;
  logic                  r_acc;
  logic                  r_dn_val;
  logic [DATA_WIDTH-1:0] r_dn_bus;
  logic                  r_dn_last;
  logic [ID_WIDTH-1:0]   r_dn_id;
  logic [DATA_WIDTH-1:0] r_sk_bus;
  logic                  r_sk_last;
  logic [ID_WIDTH-1:0]   r_sk_id;

  logic [DATA_WIDTH-1:0] w_port_bus [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_beat_bus;
  logic                  w_beat_last;
  logic                  w_owner_val;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_adv_on_xfer;
  logic                  w_locked;
  logic [SUM_WIDTH-1:0]  w_sum;
  logic [ID_WIDTH-1:0]   w_cand;
  logic [ID_WIDTH-1:0]   w_next_sel;

  // Split the flat upstream bus into per-port payloads
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_port_bus[i] = up_bus[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_beat_bus  = w_port_bus[r_sel];
  assign w_beat_last = up_last[r_sel];
  assign w_owner_val = up_val[r_sel];
  assign w_xfer      = w_owner_val & r_acc & ~rst;
  assign w_load      = ~r_dn_val | dn_rdy;

  // Only the owner may see ready, and only while the skid slot is empty
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      up_rdy[i] = (r_sel == ID_WIDTH'(i)) & r_acc & ~rst;
    end
  end

  // Next owner: first valid port after sel, wrapping and ending at sel itself;
  // scanned farthest-first so the nearest valid candidate wins
  always_comb begin
    w_next_sel = r_sel;
    w_sum      = '0;
    w_cand     = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_sum = {1'b0, r_sel} + SUM_WIDTH'(k);
      w_sum = (w_sum >= SUM_WIDTH'(NUM_PORTS)) ? (w_sum - SUM_WIDTH'(NUM_PORTS)) : w_sum;
      w_cand = w_sum[ID_WIDTH-1:0];
      w_next_sel = up_val[w_cand] ? w_cand : w_next_sel;
    end
  end

`ifdef SKID_RR_ARBITER_LOCK_EN
  logic r_locked;

  // Lock is held from a non-last beat until the owner's last beat transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
    end else if (w_xfer) begin
      r_locked <= ~w_beat_last;
    end
  end

  assign w_locked      = r_locked;
  assign w_adv_on_xfer = w_beat_last;
`else
  assign w_locked      = 1'b0;
  assign w_adv_on_xfer = 1'b1;
`endif

  assign w_advance = w_xfer ? w_adv_on_xfer : (~w_owner_val & ~w_locked);

  // Owner register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel <= '0;
    end else if (w_advance) begin
      r_sel <= w_next_sel;
    end
  end

  // Output register and skid slot; acc low means the slot holds a beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dn_val <= 1'b0;
      r_acc    <= 1'b1;
    end else if (w_load) begin
      if (!r_acc) begin
        r_dn_bus  <= r_sk_bus;
        r_dn_last <= r_sk_last;
        r_dn_id   <= r_sk_id;
        r_dn_val  <= 1'b1;
        r_acc     <= 1'b1;
      end else begin
        r_dn_val <= w_xfer;
        if (w_xfer) begin
          r_dn_bus  <= w_beat_bus;
          r_dn_last <= w_beat_last;
          r_dn_id   <= r_sel;
        end
      end
    end else if (w_xfer) begin
      r_sk_bus  <= w_beat_bus;
      r_sk_last <= w_beat_last;
      r_sk_id   <= r_sel;
      r_acc     <= 1'b0;
    end
  end

  assign dn_bus  = r_dn_bus;
  assign dn_last = r_dn_last;
  assign dn_id   = r_dn_id;
  assign dn_val  = r_dn_val;

endmodule
